// File: rtl/totient_scan_display.sv
// Two-digit multiplexed 7-segment display stage with frame-aligned value commit.
// Optional DISP_LZ_BLANK_EN blanks a leading zero in the tens position.
module totient_scan_display #(
    parameter int SCAN_DIV = 1000,
    parameter int BLANK    = 8
) (
    input  logic       clk_0,
    input  logic       R,
    input  logic [3:0] val,
    input  logic       val_valid,
    output logic       val_ready,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic [1:0] AN,
    output logic       frame
);

    localparam int MAXC = (SCAN_DIV > BLANK) ? SCAN_DIV : BLANK;
    localparam int CW   = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        BLANK_T,
        SHOW_T,
        BLANK_O,
        SHOW_O
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          run;
    logic [3:0]    disp;
    logic [3:0]    pend;
    logic          pending;
    logic [6:0]    seg;

    logic          tens;
    logic [3:0]    ones;
    logic [6:0]    tens_seg;
    logic [6:0]    ones_seg;
    logic          last;
    logic          boundary;
    logic          xfer;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign tens     = (disp >= 4'd10);
    assign ones     = disp - (tens ? 4'd10 : 4'd0);
    assign ones_seg = seg7(ones);
`ifdef DISP_LZ_BLANK_EN
    assign tens_seg = tens ? seg7(4'd1) : 7'b0000000;
`else
    assign tens_seg = seg7({3'b000, tens});
`endif

    assign last = (state == SHOW_T || state == SHOW_O)
                  ? (cnt == SHOW_LAST) : (cnt == BLANK_LAST);
    assign boundary  = run && (state == SHOW_O) && last;
    assign val_ready = R && !pending;
    assign xfer      = val_valid && val_ready;

    assign {A, B, C, D, E, F, G} = seg;

    always_ff @(posedge clk_0 or negedge R) begin
        if (!R) begin
            state   <= BLANK_T;
            cnt     <= '0;
            run     <= 1'b0;
            disp    <= 4'd0;
            pend    <= 4'd0;
            pending <= 1'b0;
            seg     <= 7'b0000000;
            AN      <= 2'b00;
            frame   <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (xfer) begin
                pend    <= val;
                pending <= 1'b1;
            end else if (boundary && pending) begin
                disp    <= pend;
                pending <= 1'b0;
            end
            // The first edge after reset opens the first frame in BLANK_T.
            if (!run) begin
                run <= 1'b1;
            end else if (last) begin
                cnt <= '0;
                unique case (state)
                    BLANK_T: begin
                        state <= SHOW_T;
                        AN    <= 2'b10;
                        seg   <= tens_seg;
                    end
                    SHOW_T: begin
                        state <= BLANK_O;
                        AN    <= 2'b00;
                        seg   <= 7'b0000000;
                    end
                    BLANK_O: begin
                        state <= SHOW_O;
                        AN    <= 2'b01;
                        seg   <= ones_seg;
                    end
                    SHOW_O: begin
                        state <= BLANK_T;
                        AN    <= 2'b00;
                        seg   <= 7'b0000000;
                        frame <= 1'b1;
                    end
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_totient_scan_display.sv
// Directed bench for totient_scan_display with SCAN_DIV=4, BLANK=1 (10-cycle frame).
module tb_totient_scan_display;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111011;
`ifdef DISP_LZ_BLANK_EN
    localparam logic [6:0] T0 = 7'b0000000;
`else
    localparam logic [6:0] T0 = S0;
`endif

    typedef struct {
        logic [3:0] v;
        logic [6:0] t;
        logic [6:0] o;
    } vec_t;

    logic       clk_0 = 1'b0;
    logic       R;
    logic [3:0] val;
    logic       val_valid;
    logic       val_ready;
    logic       A, B, C, D, E, F, G;
    logic [1:0] AN;
    logic       frame;
    logic [6:0] seg;

    int   n_vec  = 0;
    int   n_fail = 0;
    logic xfer   = 1'b0;
    logic [3:0] offers[$];
    vec_t tbl[16];

    totient_scan_display #(.SCAN_DIV(4), .BLANK(1)) dut (
        .clk_0(clk_0), .R(R), .val(val), .val_valid(val_valid),
        .val_ready(val_ready), .A(A), .B(B), .C(C), .D(D), .E(E),
        .F(F), .G(G), .AN(AN), .frame(frame)
    );

    assign seg = {A, B, C, D, E, F, G};

    always #5 clk_0 = ~clk_0;

    always @(posedge clk_0) if (val_valid && val_ready) xfer = 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, got, exp);
        end
    endtask

    // Starts at the negedge of frame cycle 0; ends at next frame's cycle 0
    // when last == 9, otherwise at the negedge of cycle 'last'.
    task automatic run_frame(input logic ef, input logic [6:0] et,
                             input logic [6:0] eo, input int rdy0,
                             input int offer_at, input int last);
        logic [1:0] ean;
        logic [6:0] eseg;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) @(negedge clk_0);
            if (xfer) begin
                chk("ready_drop", {6'b0, val_ready}, 7'd0);
                xfer = 1'b0;
                val_valid = 1'b0;
            end
            if (!val_valid && offers.size() > 0 && offer_at >= 0 &&
                i >= offer_at) begin
                val = offers.pop_front();
                val_valid = 1'b1;
            end
            if (i == 0 && rdy0 >= 0)
                chk("ready_c0", {6'b0, val_ready}, rdy0 == 1 ? 7'd1 : 7'd0);
            ean  = (i == 0 || i == 5) ? 2'b00 : (i < 5 ? 2'b10 : 2'b01);
            eseg = (i == 0 || i == 5) ? 7'b0 : (i < 5 ? et : eo);
            chk("an", {5'b0, AN}, {5'b0, ean});
            chk("seg", seg, eseg);
            chk("frame", {6'b0, frame}, (i == 0 && ef) ? 7'd1 : 7'd0);
            chk("an_excl", {6'b0, AN == 2'b11}, 7'd0);
        end
        if (last == 9) @(negedge clk_0);
    endtask

    initial begin
        tbl[0]  = '{4'd0,  T0, S0};
        tbl[1]  = '{4'd1,  T0, S1};
        tbl[2]  = '{4'd2,  T0, S2};
        tbl[3]  = '{4'd3,  T0, S3};
        tbl[4]  = '{4'd4,  T0, S4};
        tbl[5]  = '{4'd5,  T0, S5};
        tbl[6]  = '{4'd6,  T0, S6};
        tbl[7]  = '{4'd7,  T0, S7};
        tbl[8]  = '{4'd8,  T0, S8};
        tbl[9]  = '{4'd9,  T0, S9};
        tbl[10] = '{4'd10, S1, S0};
        tbl[11] = '{4'd11, S1, S1};
        tbl[12] = '{4'd12, S1, S2};
        tbl[13] = '{4'd13, S1, S3};
        tbl[14] = '{4'd14, S1, S4};
        tbl[15] = '{4'd15, S1, S5};

        R = 1'b0;
        val = 4'd0;
        val_valid = 1'b0;
        @(negedge clk_0);
        chk("rst_an", {5'b0, AN}, 7'd0);
        chk("rst_seg", seg, 7'd0);
        chk("rst_frame", {6'b0, frame}, 7'd0);
        chk("rst_ready", {6'b0, val_ready}, 7'd0);
        @(negedge clk_0);
        #2 R = 1'b1;
        @(negedge clk_0);

        // First frame after release: no frame pulse, shows 00.
        run_frame(1'b0, T0, S0, 1, -1, 9);
        // Value 12 offered mid-frame.
        offers.push_back(4'd12);
        run_frame(1'b1, T0, S0, 1, 4, 9);
        // 12 visible; offer 6 then 8 back-to-back.
        offers.push_back(4'd6);
        offers.push_back(4'd8);
        run_frame(1'b1, S1, S2, 1, 2, 9);
        run_frame(1'b1, T0, S6, 1, -1, 9);
        // Offer 10 on the last SHOW_O cycle: transfers on the boundary edge.
        offers.push_back(4'd10);
        run_frame(1'b1, T0, S8, 1, 9, 9);
        run_frame(1'b1, T0, S8, 0, -1, 9);
        // Reset during SHOW_O with a pending value.
        offers.push_back(4'd3);
        run_frame(1'b1, S1, S0, 1, 2, 7);
        #2 R = 1'b0;
        #1;
        chk("arst_an", {5'b0, AN}, 7'd0);
        chk("arst_seg", seg, 7'd0);
        chk("arst_frame", {6'b0, frame}, 7'd0);
        chk("arst_ready", {6'b0, val_ready}, 7'd0);
        val_valid = 1'b0;
        xfer = 1'b0;
        @(negedge clk_0);
        #2 R = 1'b1;
        @(negedge clk_0);
        run_frame(1'b0, T0, S0, 1, -1, 9);

        // Sweep 0-15: offer entry k, see entry k-1 the same frame.
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) offers.push_back(tbl[k].v);
            if (k == 0)
                run_frame(1'b1, T0, S0, 1, 2, 9);
            else
                run_frame(1'b1, tbl[k-1].t, tbl[k-1].o, 1,
                          k < 16 ? 2 : -1, 9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
